gray_sequence_checker: RTL and testbench
========================================

# gray_sequence_checker

Consumes the 3-bit Gray-code count produced by the modulo-8 Gray counter, converts each sample to binary and checks that successive samples advance by exactly +1 modulo 2^WIDTH. It sits directly downstream of the counter. It reports per-sample errors, lock status, a wrap pulse and a saturating error tally for the bench or a status register. All outputs are registered.

## Interface
- WIDTH, 3: Gray/binary width; the sequence modulus is 2^WIDTH.
- LOCK_GOOD, 4: consecutive correct steps required to assert `locked` (must be ≥1).
- ERR_W, 8: width of `err_count`.
- ALLOW_HOLD, 0: 1 = a repeated sample is a legal stall; 0 = a repeated sample is an error.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high; priority over all other inputs.
- in_valid  in  1  `gray_in` is sampled this cycle.
- gray_in  in  WIDTH  Gray-coded count from upstream counter.
- bin_out  out  WIDTH  binary equivalent of the last accepted sample.
- bin_valid  out  1  one-cycle pulse: `bin_out` updated.
- err_pulse  out  1  one-cycle pulse: last sample was an illegal step.
- wrap_pulse  out  1  one-cycle pulse: last sample was a correct step from 2^WIDTH-1 to 0.
- locked  out  1  LOCKED state indicator.
- err_count  out  ERR_W  number of errors since reset; saturates at all-ones.

## Operation
- Conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], from i = WIDTH-2 down to 0.
- Internal reference register `prev_bin` holds the binary value of the last sample. The expected value is (prev_bin + 1) mod 2^WIDTH, using natural WIDTH-bit wrap.
- Step classification, only when in_valid=1 and a reference exists:
  - GOOD: bin == expected.
  - HOLD: bin == prev_bin. This is legal only when ALLOW_HOLD=1; otherwise it is BAD.
  - BAD: anything else, including multi-bit Gray changes and backward steps.
- FSM states: NOREF, ACQUIRE, LOCKED. Reset state is NOREF.
  - NOREF: a valid sample loads `prev_bin` and moves to ACQUIRE with good_cnt=0. No error is possible in this state.
  - ACQUIRE:
    - GOOD: good_cnt+1. When good_cnt reaches LOCK_GOOD, go to LOCKED.
    - HOLD (legal): no change.
    - BAD: err_pulse, good_cnt=0, stay in ACQUIRE.
  - LOCKED:
    - GOOD or legal HOLD: stay.
    - BAD: err_pulse, go to ACQUIRE with good_cnt=0. `locked` deasserts.
- On every valid sample, in every state, `prev_bin` ← bin. A bad sample becomes the new reference, so one glitch costs one error and not two.
- `bin_out` and `bin_valid` are produced for every valid sample regardless of classification.
- `wrap_pulse` asserts only on a GOOD step where prev_bin = 2^WIDTH-1. It can occur in ACQUIRE or LOCKED.
- `err_count` increments on each err_pulse. It holds at 2^ERR_W-1.
- When in_valid=0: no state change, and all pulses are 0.

## Timing
- Latency is 1 cycle. A sample taken at rising edge N is reflected in every output after edge N.
- Pulses are high for exactly one cycle per valid sample. Back-to-back valid samples give back-to-back pulses.
- `locked` rises at the edge that accepts the LOCK_GOOD-th consecutive good step. It falls at the edge that accepts a BAD sample.
- Reset values: bin_out=0, bin_valid=0, err_pulse=0, wrap_pulse=0, locked=0, err_count=0, state=NOREF, good_cnt=0, prev_bin=0.
- Reset asserted mid-stream: at that edge all registers take their reset values and the concurrent sample is discarded. The first valid sample after rst falls is treated as a fresh reference, with no error.
- err_pulse and wrap_pulse are mutually exclusive.

## Test plan
- Reset, then feed the Gray sequence 000,001,011,010,110,111,101,100,000 on consecutive cycles:
  - bin_out follows 0..7,0.
  - locked=1 after the 5th sample.
  - wrap_pulse on the last sample only.
  - err_count=0.
- While locked at gray 011 (bin 2), inject 110 (bin 4), then continue 111,101,100:
  - err_pulse on 110 and locked drops.
  - No further errors.
  - locked re-asserts after the 4th good step following the error.
  - err_count=1.
- Hold case: repeat 010 twice. With ALLOW_HOLD=0, expect one err_pulse. With ALLOW_HOLD=1, expect no error and locked unchanged.
- Backward step 101→111 (bin 6→5) gives err_pulse. Then 010 directly after 000 (0→3) also gives err_pulse. err_count=2.
- Assert rst for one cycle mid-sequence with in_valid=1:
  - All outputs return to reset values.
  - The next sample (any value) produces bin_valid with no err_pulse.
- With ERR_W=2, force 5 errors: err_count saturates at 3.

Source files
------------

// File: rtl/gray_sequence_checker.sv
// Gray-code sequence checker: converts each Gray sample to binary and verifies
// that consecutive samples advance by +1 mod 2^WIDTH, with lock tracking.
module gray_sequence_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_GOOD  = 4,
    parameter int ERR_W      = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = $clog2(LOCK_GOOD + 1);

    typedef enum logic [1:0] {NOREF, ACQUIRE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0]   prev_bin_q, prev_bin_d;
    logic [WIDTH-1:0]   bin_out_q, bin_out_d;
    logic               bin_valid_q, bin_valid_d;
    logic               err_pulse_q, err_pulse_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic               locked_q, locked_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]   bin;
    logic [WIDTH-1:0]   expected;
    logic               has_ref, is_good, is_hold, step_bad;

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray_in[i];
        end
    end

    // A hold can never alias a good step since +1 mod 2^WIDTH never equals itself.
    always_comb begin
        expected = WIDTH'(prev_bin_q + 1'b1);
        has_ref  = (state_q != NOREF);
        is_good  = (bin == expected);
        is_hold  = (bin == prev_bin_q);
        step_bad = in_valid && has_ref && !is_good && !(is_hold && (ALLOW_HOLD != 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NOREF;
            good_cnt_q   <= '0;
            prev_bin_q   <= '0;
            bin_out_q    <= '0;
            bin_valid_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            prev_bin_q   <= prev_bin_d;
            bin_out_q    <= bin_out_d;
            bin_valid_q  <= bin_valid_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            locked_q     <= locked_d;
            err_count_q  <= err_count_d;
        end
    end

    // Every valid sample becomes the new reference, including bad ones.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        prev_bin_d = prev_bin_q;
        if (in_valid) begin
            prev_bin_d = bin;
            case (state_q)
                NOREF: begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
                ACQUIRE: begin
                    if (is_good) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q == CNT_W'(LOCK_GOOD - 1)) state_d = LOCKED;
                    end else if (step_bad) begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (step_bad) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = NOREF;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        bin_out_d    = in_valid ? bin : bin_out_q;
        bin_valid_d  = in_valid;
        err_pulse_d  = step_bad;
        wrap_pulse_d = in_valid && has_ref && is_good && (prev_bin_q == {WIDTH{1'b1}});
        locked_d     = (state_d == LOCKED);
        err_count_d  = err_count_q;
        if (step_bad && (err_count_q != {ERR_W{1'b1}})) err_count_d = err_count_q + 1'b1;
    end

    assign bin_out    = bin_out_q;
    assign bin_valid  = bin_valid_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign locked     = locked_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_sequence_checker.sv
// Directed bench for gray_sequence_checker: three instances (default, hold-tolerant,
// 2-bit error counter) share one stimulus stream.
module tb_gray_sequence_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] gray_in = 3'b000;

    logic [2:0] bo_a, bo_h, bo_e;
    logic       bv_a, bv_h, bv_e;
    logic       ep_a, ep_h, ep_e;
    logic       wp_a, wp_h, wp_e;
    logic       lk_a, lk_h, lk_e;
    logic [7:0] ec_a, ec_h;
    logic [1:0] ec_e;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gray_sequence_checker #(.WIDTH(3), .LOCK_GOOD(4), .ERR_W(8), .ALLOW_HOLD(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .bin_out(bo_a), .bin_valid(bv_a), .err_pulse(ep_a), .wrap_pulse(wp_a),
        .locked(lk_a), .err_count(ec_a));

    gray_sequence_checker #(.WIDTH(3), .LOCK_GOOD(4), .ERR_W(8), .ALLOW_HOLD(1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .bin_out(bo_h), .bin_valid(bv_h), .err_pulse(ep_h), .wrap_pulse(wp_h),
        .locked(lk_h), .err_count(ec_h));

    gray_sequence_checker #(.WIDTH(3), .LOCK_GOOD(4), .ERR_W(2), .ALLOW_HOLD(0)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .bin_out(bo_e), .bin_valid(bv_e), .err_pulse(ep_e), .wrap_pulse(wp_e),
        .locked(lk_e), .err_count(ec_e));

    task automatic send(input logic [2:0] g);
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bo_a, bv_a, ep_a, wp_a, lk_a, ec_a} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {bo_a, bv_a, ep_a, wp_a, lk_a, ec_a});
        end
    endtask

    task automatic test_sequence();
        logic [2:0] g_seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};
        logic [2:0] b_seq [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(g_seq[i]);
            n_cmp++;
            if ({bo_a, bv_a, ep_a, wp_a, lk_a} !== {b_seq[i], 1'b1, 1'b0, (i == 8), (i >= 4)}) begin
                n_bad++;
                $display("FAIL seq[%0d]: got bin=%0d v=%b e=%b w=%b l=%b want bin=%0d v=1 e=0 w=%b l=%b",
                         i, bo_a, bv_a, ep_a, wp_a, lk_a, b_seq[i], (i == 8), (i >= 4));
            end
        end
        n_cmp++;
        if (ec_a !== 8'd0) begin
            n_bad++;
            $display("FAIL seq_errcnt: got %0d want 0", ec_a);
        end
        idle();
        n_cmp++;
        if ({bo_a, bv_a, ep_a, wp_a, lk_a} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL idle_hold: got bin=%0d v=%b e=%b w=%b l=%b want bin=0 v=0 e=0 w=0 l=1",
                     bo_a, bv_a, ep_a, wp_a, lk_a);
        end
    endtask

    // Locked at bin 0; step to 2, glitch to 4, then four good steps relock.
    task automatic test_glitch();
        logic [2:0] g_seq [7] = '{3'b001, 3'b011, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        logic       e_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       l_exp [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       w_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            send(g_seq[i]);
            n_cmp++;
            if ({ep_a, lk_a, wp_a} !== {e_exp[i], l_exp[i], w_exp[i]}) begin
                n_bad++;
                $display("FAIL glitch[%0d]: got e=%b l=%b w=%b want e=%b l=%b w=%b",
                         i, ep_a, lk_a, wp_a, e_exp[i], l_exp[i], w_exp[i]);
            end
        end
        n_cmp++;
        if (ec_a !== 8'd1) begin
            n_bad++;
            $display("FAIL glitch_errcnt: got %0d want 1", ec_a);
        end
    endtask

    task automatic test_hold();
        logic [2:0] g_seq [5] = '{3'b100, 3'b000, 3'b001, 3'b011, 3'b010};
        do_reset();
        for (int i = 0; i < 5; i++) send(g_seq[i]);
        n_cmp++;
        if ({lk_a, lk_h} !== 2'b11) begin
            n_bad++;
            $display("FAIL hold_prelock: got a=%b h=%b want 11", lk_a, lk_h);
        end
        send(3'b010);
        n_cmp++;
        if ({ep_a, lk_a, ec_a, bv_a, bo_a} !== {1'b1, 1'b0, 8'd1, 1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL hold_strict: got e=%b l=%b cnt=%0d v=%b bin=%0d want e=1 l=0 cnt=1 v=1 bin=3",
                     ep_a, lk_a, ec_a, bv_a, bo_a);
        end
        n_cmp++;
        if ({ep_h, lk_h, ec_h, bv_h, bo_h} !== {1'b0, 1'b1, 8'd0, 1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL hold_allowed: got e=%b l=%b cnt=%0d v=%b bin=%0d want e=0 l=1 cnt=0 v=1 bin=3",
                     ep_h, lk_h, ec_h, bv_h, bo_h);
        end
    endtask

    // 0..6, back to 5 (err), 6, 7, 0 (wrap), then 3 (err).
    task automatic test_backward();
        logic [2:0] g_seq [7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101};
        do_reset();
        for (int i = 0; i < 7; i++) send(g_seq[i]);
        send(3'b111);
        n_cmp++;
        if ({ep_a, wp_a, lk_a, bo_a} !== {1'b1, 1'b0, 1'b0, 3'd5}) begin
            n_bad++;
            $display("FAIL backward_err: got e=%b w=%b l=%b bin=%0d want e=1 w=0 l=0 bin=5",
                     ep_a, wp_a, lk_a, bo_a);
        end
        send(3'b101);
        send(3'b100);
        send(3'b000);
        n_cmp++;
        if ({ep_a, wp_a} !== 2'b01) begin
            n_bad++;
            $display("FAIL wrap_in_acquire: got e=%b w=%b want e=0 w=1", ep_a, wp_a);
        end
        send(3'b010);
        n_cmp++;
        if ({ep_a, wp_a, ec_a} !== {1'b1, 1'b0, 8'd2}) begin
            n_bad++;
            $display("FAIL jump_err: got e=%b w=%b cnt=%0d want e=1 w=0 cnt=2", ep_a, wp_a, ec_a);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] g_seq [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
        do_reset();
        for (int i = 0; i < 5; i++) send(g_seq[i]);
        send(3'b010);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        gray_in = 3'b111;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bo_a, bv_a, ep_a, wp_a, lk_a, ec_a} !== 14'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b want 0", {bo_a, bv_a, ep_a, wp_a, lk_a, ec_a});
        end
        @(negedge clk);
        rst = 1'b0;
        gray_in = 3'b101;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bo_a, bv_a, ep_a, lk_a, ec_a} !== {3'd6, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL midreset_fresh: got bin=%0d v=%b e=%b l=%b cnt=%0d want bin=6 v=1 e=0 l=0 cnt=0",
                     bo_a, bv_a, ep_a, lk_a, ec_a);
        end
        send(3'b100);
        n_cmp++;
        if ({bo_a, ep_a} !== {3'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL midreset_next: got bin=%0d e=%b want bin=7 e=0", bo_a, ep_a);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] e_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        send(3'b000);
        for (int i = 0; i < 5; i++) begin
            send((i % 2 == 0) ? 3'b010 : 3'b000);
            n_cmp++;
            if ({ep_e, ec_e} !== {1'b1, e_cnt[i]}) begin
                n_bad++;
                $display("FAIL saturate[%0d]: got e=%b cnt=%0d want e=1 cnt=%0d", i, ep_e, ec_e, e_cnt[i]);
            end
        end
        n_cmp++;
        if (ec_a !== 8'd5) begin
            n_bad++;
            $display("FAIL wide_count: got %0d want 5", ec_a);
        end
        idle();
        n_cmp++;
        if ({ep_e, ec_e} !== {1'b0, 2'd3}) begin
            n_bad++;
            $display("FAIL saturate_idle: got e=%b cnt=%0d want e=0 cnt=3", ep_e, ec_e);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_glitch();
        test_hold();
        test_backward();
        test_mid_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
